// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: IF stage with IF/ID register, B/BL redirect in ID and stall support.
module fetch_decode_stage #(
    parameter int          PC_W  = 8,
    parameter logic [31:0] NOP   = 32'h00000000,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             cond_true,
    input  logic [31:0]      imem_data,
    output logic [PC_W-1:0]  imem_addr,
    output logic [31:0]      id_instr,
    output logic [PC_W-1:0]  id_pc,
    output logic             id_valid,
    output logic             branch_taken,
    output logic [PC_W-1:0]  branch_target,
    output logic [CNT_W-1:0] fetch_count
);
    logic [PC_W-1:0] pc;
    logic [31:0]     offset;
    logic            is_branch;

    assign imem_addr = pc;

    always_comb begin
        offset        = {{6{id_instr[23]}}, id_instr[23:0], 2'b00};
        is_branch     = id_valid && (id_instr[27:25] == 3'b101);
        branch_taken  = is_branch && cond_true && !stall;
        branch_target = id_pc + PC_W'(8) + offset[PC_W-1:0];
    end

    // Taken branch squashes the wrong-path word fetched alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            id_instr    <= NOP;
            id_pc       <= '0;
            id_valid    <= 1'b0;
            fetch_count <= '0;
        end else if (!stall) begin
            if (branch_taken) begin
                pc       <= branch_target;
                id_instr <= NOP;
                id_pc    <= '0;
                id_valid <= 1'b0;
            end else begin
                pc          <= pc + PC_W'(4);
                id_instr    <= imem_data;
                id_pc       <= pc;
                id_valid    <= 1'b1;
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: directed scenarios plus randomized run against a spec-level model.
module tb_fetch_decode_stage;
    logic        clk = 0;
    logic        reset = 1, stall = 0, cond_true = 0;
    logic [31:0] imem_data;
    logic [7:0]  imem_addr, id_pc, branch_target;
    logic [31:0] id_instr;
    logic        id_valid, branch_taken;
    logic [3:0]  fetch_count;
    logic [31:0] mem [64];
    int total = 0, bad = 0;
    int mpc, minstr, midpc, mvalid, mcnt;

    fetch_decode_stage #(.PC_W(8), .NOP(32'h0), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .cond_true(cond_true),
        .imem_data(imem_data), .imem_addr(imem_addr), .id_instr(id_instr),
        .id_pc(id_pc), .id_valid(id_valid), .branch_taken(branch_taken),
        .branch_target(branch_target), .fetch_count(fetch_count)
    );

    assign imem_data = mem[imem_addr[7:2]];
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] plain_word();
        return $urandom & ~32'h0E000000;
    endfunction

    task automatic fill_plain();
        for (int i = 0; i < 64; i++) mem[i] = plain_word();
    endtask

    task automatic restart(input int n);
        reset = 1; stall = 0;
        tick();
        reset = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic int m_target();
        int imm;
        imm = minstr & 32'h00FFFFFF;
        if (imm >= (1 << 23)) imm -= (1 << 24);
        return (((midpc + 8 + imm * 4) % 256) + 256) % 256;
    endfunction

    function automatic int m_taken();
        return (mvalid != 0 && ((minstr >> 25) & 7) == 5 && cond_true && !stall) ? 1 : 0;
    endfunction

    task automatic test_reset();
        fill_plain();
        reset = 1; stall = 1'($urandom); cond_true = 1'($urandom);
        tick(); tick();
        total++; if (imem_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
        total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", id_instr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        total++; if (fetch_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", branch_taken); end
    endtask

    task automatic test_fetch();
        reset = 0; stall = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++; if (imem_addr !== 8'(4 * k)) begin bad++; $display("FAIL fetch_addr k=%0d got=%0d exp=%0d", k, imem_addr, 4 * k); end
            total++; if (id_pc !== 8'(4 * (k - 1))) begin bad++; $display("FAIL fetch_idpc k=%0d got=%0d exp=%0d", k, id_pc, 4 * (k - 1)); end
            total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid k=%0d got=%b exp=1", k, id_valid); end
            total++; if (id_instr !== mem[k - 1]) begin bad++; $display("FAIL fetch_instr k=%0d got=%h exp=%h", k, id_instr, mem[k - 1]); end
            total++; if (fetch_count !== 4'(k)) begin bad++; $display("FAIL fetch_count k=%0d got=%0d exp=%0d", k, fetch_count, k); end
        end
    endtask

    task automatic test_stall();
        restart(2);
        stall = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (imem_addr !== 8'd8) begin bad++; $display("FAIL stall_addr got=%0d exp=8", imem_addr); end
            total++; if (id_pc !== 8'd4 || id_instr !== mem[1]) begin bad++; $display("FAIL stall_ifid got=%0d/%h exp=4/%h", id_pc, id_instr, mem[1]); end
            total++; if (fetch_count !== 4'd2) begin bad++; $display("FAIL stall_count got=%0d exp=2", fetch_count); end
        end
        stall = 0;
        tick();
        total++; if (id_pc !== 8'd8 || id_instr !== mem[2]) begin bad++; $display("FAIL stall_resume got=%0d/%h exp=8/%h", id_pc, id_instr, mem[2]); end
        total++; if (imem_addr !== 8'd12 || fetch_count !== 4'd3) begin bad++; $display("FAIL stall_resume_pc got=%0d/%0d exp=12/3", imem_addr, fetch_count); end
    endtask

    task automatic test_branch();
        fill_plain();
        mem[4] = 32'h1AFFFFFD;
        cond_true = 1;
        restart(5);
        total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL br_taken got=%b exp=1", branch_taken); end
        total++; if (branch_target !== 8'd12) begin bad++; $display("FAIL br_target got=%0d exp=12", branch_target); end
        tick();
        total++; if (imem_addr !== 8'd12 || id_valid !== 1'b0) begin bad++; $display("FAIL br_redirect got=%0d/%b exp=12/0", imem_addr, id_valid); end
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL br_bubble_taken got=%b exp=0", branch_taken); end
        tick();
        total++; if (id_pc !== 8'd12 || id_valid !== 1'b1 || id_instr !== mem[3]) begin bad++; $display("FAIL br_target_ifid got=%0d/%b/%h exp=12/1/%h", id_pc, id_valid, id_instr, mem[3]); end
        cond_true = 0;
        restart(5);
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL br_nottaken got=%b exp=0", branch_taken); end
        tick();
        total++; if (imem_addr !== 8'd24 || id_pc !== 8'd20) begin bad++; $display("FAIL br_fallthru got=%0d/%0d exp=24/20", imem_addr, id_pc); end
    endtask

    task automatic test_branch_stall();
        cond_true = 1;
        restart(5);
        stall = 1;
        #1;
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL brst_taken got=%b exp=0", branch_taken); end
        tick();
        total++; if (imem_addr !== 8'd20 || id_pc !== 8'd16) begin bad++; $display("FAIL brst_hold got=%0d/%0d exp=20/16", imem_addr, id_pc); end
        stall = 0;
        #1;
        total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL brst_release got=%b exp=1", branch_taken); end
        tick();
        total++; if (imem_addr !== 8'd12 || id_valid !== 1'b0) begin bad++; $display("FAIL brst_redirect got=%0d/%b exp=12/0", imem_addr, id_valid); end
        restart(5);
        reset = 1;
        tick();
        reset = 0;
        total++; if (imem_addr !== 8'd0 || id_valid !== 1'b0 || fetch_count !== 4'd0) begin bad++; $display("FAIL brst_reset got=%0d/%b/%0d exp=0/0/0", imem_addr, id_valid, fetch_count); end
    endtask

    task automatic test_wrap();
        fill_plain();
        mem[62] = 32'hEA000001;
        cond_true = 0;
        restart(16);
        total++; if (fetch_count !== 4'd0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", fetch_count); end
        for (int i = 0; i < 47; i++) tick();
        total++; if (imem_addr !== 8'd252 || id_pc !== 8'd248) begin bad++; $display("FAIL wrap_pre got=%0d/%0d exp=252/248", imem_addr, id_pc); end
        total++; if (branch_target !== 8'd4) begin bad++; $display("FAIL wrap_target got=%0d exp=4", branch_target); end
        tick();
        total++; if (imem_addr !== 8'd0) begin bad++; $display("FAIL wrap_pc got=%0d exp=0", imem_addr); end
        restart(63);
        cond_true = 1;
        #1;
        total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL wrap_taken got=%b exp=1", branch_taken); end
        tick();
        total++; if (imem_addr !== 8'd4) begin bad++; $display("FAIL wrap_redirect got=%0d exp=4", imem_addr); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(3) != 0) mem[i] &= ~32'h0E000000;
        end
        reset = 1; stall = 0;
        mpc = 0; minstr = 0; midpc = 0; mvalid = 0; mcnt = 0;
        tick();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(40) == 0);
            stall = ($urandom_range(3) == 0);
            cond_true = 1'($urandom);
            #1;
            total++; if (branch_taken !== 1'(m_taken())) begin bad++; $display("FAIL rnd_taken c=%0d got=%b exp=%0d", c, branch_taken, m_taken()); end
            total++; if (branch_target !== 8'(m_target())) begin bad++; $display("FAIL rnd_target c=%0d got=%0d exp=%0d", c, branch_target, m_target()); end
            if (reset) begin
                mpc = 0; minstr = 0; midpc = 0; mvalid = 0; mcnt = 0;
            end else if (!stall) begin
                if (m_taken() != 0) begin
                    mpc = m_target(); minstr = 0; midpc = 0; mvalid = 0;
                end else begin
                    minstr = mem[mpc / 4]; midpc = mpc; mvalid = 1;
                    mpc = (mpc + 4) % 256; mcnt = (mcnt + 1) % 16;
                end
            end
            tick();
            total++; if (imem_addr !== 8'(mpc)) begin bad++; $display("FAIL rnd_addr c=%0d got=%0d exp=%0d", c, imem_addr, mpc); end
            total++; if (id_instr !== 32'(minstr)) begin bad++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, id_instr, minstr); end
            total++; if (id_pc !== 8'(midpc)) begin bad++; $display("FAIL rnd_idpc c=%0d got=%0d exp=%0d", c, id_pc, midpc); end
            total++; if (id_valid !== 1'(mvalid)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%0d", c, id_valid, mvalid); end
            total++; if (fetch_count !== 4'(mcnt)) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, fetch_count, mcnt); end
        end
        reset = 0; stall = 0;
    endtask

    initial begin
        #2;
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_branch_stall();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
